// File: rtl/atm_session_timer_if.sv
// Command/status bundle between the ATM main FSM and the session timer.
// slow_clk rides along as plain sampled data from the clock divider.
interface atm_session_timer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             slow_clk;
    logic             start;
    logic             activity;
    logic             cancel;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             warning;
    logic             timeout;
    logic             expired;

    modport master (
        output slow_clk, start, activity, cancel,
        input  remaining, busy, warning, timeout, expired
    );

    modport slave (
        input  slow_clk, start, activity, cancel,
        output remaining, busy, warning, timeout, expired
    );
endinterface

// File: rtl/atm_session_timer.sv
// Idle-session timer: turns slow_clk rising edges into clk-domain ticks and counts
// them down from a programmed timeout, flagging warning and expiry to the main FSM.
module atm_session_timer #(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned WARN_TICKS    = 5,
    parameter int unsigned CNT_W         = 8
) (
    input logic                clk,
    input logic                rst,
    atm_session_timer_if.slave bus
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] WarnVal    = CNT_W'(WARN_TICKS);

    typedef enum logic [1:0] {StIdle, StRun, StWarn, StExpired} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d, remaining_dec;
    logic             timeout_q, timeout_d;
    logic             s1_q, s2_q, prev_q;
    logic             tick;

    // slow_clk is asynchronous data: synchronize, then detect rising edges only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= bus.slow_clk;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign tick = s2_q & ~prev_q;

    // Saturating decrement keeps the counter from ever wrapping below zero
    assign remaining_dec = (remaining_q != '0) ? remaining_q - 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                remaining_d = '0;
                if (!bus.cancel && bus.start) begin
                    state_d     = StRun;
                    remaining_d = TimeoutVal;
                end
            end
            StRun: begin
                if (bus.cancel) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (bus.start || bus.activity) begin
                    remaining_d = TimeoutVal;
                end else if (tick) begin
                    remaining_d = remaining_dec;
                    if (remaining_dec == WarnVal) begin
                        state_d = StWarn;
                    end
                end
            end
            StWarn: begin
                if (bus.cancel) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (bus.start || bus.activity) begin
                    state_d     = StRun;
                    remaining_d = TimeoutVal;
                end else if (tick) begin
                    remaining_d = remaining_dec;
                    if (remaining_dec == '0) begin
                        state_d   = StExpired;
                        timeout_d = 1'b1;
                    end
                end
            end
            StExpired: begin
                remaining_d = '0;
                if (bus.cancel) begin
                    state_d = StIdle;
                end else if (bus.start) begin
                    state_d     = StRun;
                    remaining_d = TimeoutVal;
                end
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
        endcase
    end

    assign bus.remaining = remaining_q;
    assign bus.busy      = (state_q == StRun) || (state_q == StWarn);
    assign bus.warning   = (state_q == StWarn);
    assign bus.expired   = (state_q == StExpired);
    assign bus.timeout   = timeout_q;

endmodule

// File: doc/atm_session_timer.md
# atm_session_timer

Session-timeout timer for the ATM controller. It consumes the divided `slow_clk` from the clock divider as a sampled data signal and converts each of its rising edges into a one-cycle tick in the `clk` domain. It counts the ticks down from a programmed timeout and flags a warning and then an expiry to the main ATM FSM. Keypad activity reloads the count, so an idle customer session (card inserted, no input) is aborted deterministically.

## Interface
- `TIMEOUT_TICKS`, default 30: ticks from start/activity to expiry; legal range 2 ≤ TIMEOUT_TICKS < 2^CNT_W.
- `WARN_TICKS`, default 5: remaining-tick count at which `warning` asserts; legal range 1 ≤ WARN_TICKS < TIMEOUT_TICKS.
- `CNT_W`, default 8: width of the tick counter.
- `clk` in 1: system clock. The only clock in the block.
- `rst` in 1: reset, asynchronous, active-high.
- `slow_clk` in 1: divided clock from the clock divider. Treated as asynchronous data and never used as a clock.
- `start` in 1: begin or restart a session; one-cycle pulse.
- `activity` in 1: keypad/user activity; one-cycle pulse; reloads the count.
- `cancel` in 1: session ended normally; returns the block to IDLE.
- `remaining` out CNT_W: ticks left before expiry.
- `busy` out 1: high in RUN or WARN.
- `warning` out 1: high in WARN.
- `timeout` out 1: one-cycle pulse on entry to EXPIRED.
- `expired` out 1: level, high in EXPIRED.

## Operation
- **Tick generation**
  - `slow_clk` passes through a 2-flop synchronizer (s1, s2), then an edge register `prev`.
  - `tick = s2 & ~prev`, combinational.
  - s1, s2 and `prev` all reset to 0.
- **States:** IDLE, RUN, WARN, EXPIRED. Reset state is IDLE.
- **Command priority** (same cycle, highest first): `cancel` > `start` > `activity` > `tick`.
- **IDLE**
  - `remaining` = 0; ticks ignored.
  - `start` → RUN, with `remaining` = TIMEOUT_TICKS.
  - `activity` is ignored.
- **RUN**
  - `cancel` → IDLE, `remaining` = 0.
  - `start` or `activity` → reload `remaining` = TIMEOUT_TICKS and stay in RUN. No decrement that cycle, even if a tick is present.
  - `tick` → `remaining` − 1. If the new value equals WARN_TICKS, go to WARN.
- **WARN**
  - `cancel` → IDLE.
  - `start` or `activity` → RUN, with a reload to TIMEOUT_TICKS.
  - `tick` → `remaining` − 1. If the new value is 0, go to EXPIRED.
- **EXPIRED**
  - `remaining` holds 0; ticks ignored.
  - `start` → RUN with a reload; `cancel` → IDLE.
  - `activity` is ignored, and `expired` stays high until one of these commands arrives.
- **Counter range:** `remaining` never wraps. It is never decremented at 0, and it never exceeds TIMEOUT_TICKS.
- **Outputs:** all outputs are registered and decoded from the state register, apart from `timeout`, which is a registered one-cycle pulse.

## Timing
- **Reset values:** `remaining` = 0; `busy`, `warning`, `timeout`, `expired` = 0; state IDLE. Reset takes effect immediately and asynchronously, including mid-session; no pulse is emitted.
- **Tick latency:** when `slow_clk` is first sampled high at clk edge N, `tick` is high during the cycle after edge N+1. The counter updates at edge N+2. Exactly one tick occurs per `slow_clk` rising edge, and falling edges produce none.
- **Tick after reset:** if `slow_clk` is high when `rst` deasserts, one tick occurs 2 cycles after release. In IDLE it is harmless. If `start` arrives within those 2 cycles, that tick counts.
- **Command latency:** `start`, `activity` and `cancel` take effect at the clock edge on which they are sampled. The new state and `remaining` are visible the next cycle.
- **Warning:** `warning` rises in the cycle after the tick that brings `remaining` to WARN_TICKS.
- **Expiry:** `timeout` and `expired` both rise in the cycle after the tick that brings `remaining` to 0. `timeout` lasts exactly 1 cycle.
- **Total duration:** from `start` to `timeout` is TIMEOUT_TICKS `slow_clk` rising edges, plus 3 clk cycles of synchronizer and register latency.

## Test plan
All scenarios use TIMEOUT_TICKS=4, WARN_TICKS=2, CNT_W=8, with `slow_clk` of period 16 clk (8 high, 8 low).
- **Plain timeout:** pulse `start`.
  - `busy`=1 and `remaining`=4 the next cycle.
  - After the 2nd `slow_clk` rise, `remaining`=2 and `warning`=1.
  - After the 4th rise, `remaining`=0, `timeout` is a 1-cycle pulse and `expired`=1 and stays high.
- **Activity reload:** pulse `activity` in WARN with `remaining`=1. The block returns to RUN with `remaining`=4 and `warning`=0. A tick in that same cycle is discarded, so `remaining`=4, not 3.
- **Priority:** assert `cancel`, `start` and `tick` in the same cycle during RUN. The block goes to IDLE with `remaining`=0 and `busy`=0. Separately, `start` plus `tick` in RUN gives `remaining`=4.
- **Expired handling:**
  - In EXPIRED, `activity` has no effect and `expired` stays 1.
  - `start` gives RUN with `remaining`=4.
  - `cancel` from EXPIRED gives IDLE with `expired`=0.
- **Reset mid-session:** assert `rst` asynchronously in WARN. All outputs go to 0 immediately, with no `timeout` pulse. After release, ticks do not change `remaining` until `start`.
- **Edge detect:** hold `slow_clk` high for 40 clk. Exactly one decrement occurs. A falling edge produces no decrement.
